complex_op_arbiter: RTL and testbench
=====================================

COMPLEX_OP_ARBITER -- requirements
Module: complex_op_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req0_valid  input  1  SHALL flag that requester 0 presents an operand pair.
REQ-005 req0_a, req0_b  input  WIDTH each  SHALL be requester 0 operands d1 and d2.
REQ-006 req0_ready  output  1  SHALL flag that the block accepts requester 0 this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready SHALL be identical to REQ-004..006 for requester 1.
REQ-008 rsp_valid  output  1  SHALL flag that a result is presented.
REQ-009 rsp_data  output  WIDTH  SHALL be the result.
REQ-010 rsp_id  output  1  SHALL be the index of the requester that issued the result.
REQ-011 rsp_ready  input  1  SHALL flag that the consumer accepts the result this cycle.

Function
REQ-012 Operation SHALL be result = ((a & b) | (a ^ b)) + b, truncated modulo 2^WIDTH; the carry out is discarded.
REQ-013 Transfer rule SHALL be: request accepted when valid & ready in the same cycle; response consumed when rsp_valid & rsp_ready.
REQ-014 Datapath SHALL be a 2-stage pipeline: S1 registers the granted operands and id; S2 registers the computed result and id onto rsp_*.
REQ-015 Advance condition SHALL be adv = !rsp_valid | rsp_ready; S2 loads from S1 and S1 loads from the arbiter only when adv = 1.
REQ-016 While adv = 0, S1, S2, rsp_data and rsp_id SHALL hold stable, and both req*_ready SHALL be 0.
REQ-017 Latency SHALL be 2 cycles: a request accepted at edge N with no backpressure yields rsp_valid = 1 after edge N+2.
REQ-018 Throughput SHALL be one request per cycle when rsp_ready stays 1.
REQ-019 The arbiter SHALL assert at most one req*_ready per cycle; req*_ready may depend combinationally on both req*_valid and on adv.
REQ-020 Single valid requester SHALL be granted whenever adv = 1.
REQ-021 Both requesters valid SHALL be resolved round-robin: grant the requester not granted last.
REQ-022 The last-grant pointer SHALL update only on an accepted request, and reset to 1 so that requester 0 wins the first contention.
REQ-023 No valid requester with adv = 1 SHALL load a bubble into S1 (valid = 0); the pointer is unchanged.
REQ-024 A requester whose valid is held while its ready = 0 SHALL not be starved: it is granted within 2 accepted transfers.
REQ-025 Bubbles SHALL be collapsed: if S2 is invalid, S1 advances regardless of rsp_ready.
REQ-026 Operands SHALL be sampled only on acceptance; changes to req*_a/b while not accepted have no effect.

Reset
REQ-027 While rst = 1: rsp_valid = 0, S1 valid = 0, req0_ready = req1_ready = 0, and last-grant = 1.
REQ-028 rsp_data and rsp_id SHALL reset to 0.
REQ-029 rst asserted mid-operation SHALL discard all in-flight requests with no response emitted for them.
REQ-030 A request offered in the first cycle after rst deasserts SHALL be acceptable.

Verification
REQ-031 Basic: req0 a=0x1234, b=0x00FF, rsp_ready=1 -> 2 cycles later rsp_data=0x13FE, rsp_id=0, for exactly one cycle.
REQ-032 Wrap: req1 a=0xFFFF, b=0x0001 -> rsp_data=0x0000, rsp_id=1.
REQ-033 Contention: both valid continuously for 4 accepts after reset -> grant order 0,1,0,1; responses in the same order with matching results.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles with a result pending -> rsp_data/rsp_id stable, both ready=0; on release, results drain in order with none lost or duplicated.
REQ-035 Reset mid-flight: 2 requests in pipeline, pulse rst for 1 cycle -> no rsp_valid for them; next req0 a=0x0F0F, b=0x00F0 -> rsp_data=0x10EF.
REQ-036 Random: constrained-random valid/ready on both sides, 10k cycles -> scoreboard matches REQ-012 per id, no starvation beyond REQ-024.

Source files
------------

// File: rtl/complex_op_arbiter.sv
// complex_op_arbiter: two-requester round-robin arbiter in front of a
// two-stage pipelined datapath computing ((a & b) | (a ^ b)) + b.
// Stage S1 holds the granted operands and requester id; stage S2 holds the
// result and id and drives rsp_*. Both stages move together whenever the
// output is empty or being consumed, so internal bubbles never block traffic.
module complex_op_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready
);

  logic             adv;
  logic             grant0;
  logic             grant1;
  logic             last_grant;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_id;
  logic [WIDTH-1:0] s1_result;

  // The whole pipeline advances when the output slot is empty or being taken.
  always_comb begin
    adv = !rsp_valid || rsp_ready;
  end

  // Round-robin grant: a lone requester always wins, contention goes to the
  // requester that did not win last time; nothing is granted during a stall
  // or while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && adv) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Last-grant pointer moves only on an accepted request; resets to 1 so
  // requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Stage S1: capture the granted operands and id, or a bubble if no grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= 1'b0;
    end else if (adv) begin
      s1_valid <= grant0 || grant1;
      if (grant1) begin
        s1_a  <= req1_a;
        s1_b  <= req1_b;
        s1_id <= 1'b1;
      end else if (grant0) begin
        s1_a  <= req0_a;
        s1_b  <= req0_b;
        s1_id <= 1'b0;
      end
    end
  end

  // Result of the S1 operands, truncated to WIDTH bits (carry dropped).
  always_comb begin
    s1_result = ((s1_a & s1_b) | (s1_a ^ s1_b)) + s1_b;
  end

  // Stage S2: register the result and id onto the response port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= s1_result;
        rsp_id   <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_complex_op_arbiter.sv
// Self-checking bench for complex_op_arbiter: directed scenarios followed by
// constrained-random traffic, all scored against a transaction-level model
// (an in-order result queue with a fixed two-cycle visibility delay plus a
// round-robin grant rule).
module tb_complex_op_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_ready;

  always #5 clk = ~clk;

  complex_op_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             id;
    int               cyc;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;
  logic  model_last = 1'b1;
  int    wait_cnt [2];

  // Reference operation written straight from the arithmetic definition.
  function automatic logic [WIDTH-1:0] op_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned full;
    full = int'((a & b) | (a ^ b)) + int'(b);
    return WIDTH'(full % (32'd1 << WIDTH));
  endfunction

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then at the falling
  // edge compare everything against the model and advance the model to what
  // the next rising edge will do.
  task automatic applyStimulus(input logic r,
                               input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                               input logic rr);
    logic exp_valid;
    logic adv;
    logic e0;
    logic e1;
    @(posedge clk);
    #1;
    rst        = r;
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    rsp_ready  = rr;
    @(negedge clk);
    cycle++;
    if (r) begin
      checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
      checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
      sb.delete();
      model_last  = 1'b1;
      wait_cnt[0] = 0;
      wait_cnt[1] = 0;
      return;
    end
    exp_valid = (sb.size() > 0) && (sb[0].cyc + 2 <= cycle);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("rsp_data", 32'(rsp_data), 32'(sb[0].data));
      checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
    end
    adv = !exp_valid || rr;
    e0  = 1'b0;
    e1  = 1'b0;
    if (adv && (v0 || v1)) begin
      if (v0 && v1) begin
        e1 = !model_last;
        e0 = model_last;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    checkOutput("ready0", 32'(req0_ready), 32'(e0));
    checkOutput("ready1", 32'(req1_ready), 32'(e1));
    if (exp_valid && rr) begin
      void'(sb.pop_front());
    end
    if (!v0) wait_cnt[0] = 0;
    if (!v1) wait_cnt[1] = 0;
    if (e0 || e1) begin
      if (e1) sb.push_back('{data: op_ref(a1, b1), id: 1'b1, cyc: cycle});
      else    sb.push_back('{data: op_ref(a0, b0), id: 1'b0, cyc: cycle});
      model_last = e1;
      wait_cnt[e1 ? 1 : 0] = 0;
      if (e1 && v0) begin
        wait_cnt[0]++;
        checkOutput("starve0", 32'(wait_cnt[0] > 2), 32'd0);
      end
      if (e0 && v1) begin
        wait_cnt[1]++;
        checkOutput("starve1", 32'(wait_cnt[1] > 2), 32'd0);
      end
    end
  endtask

  task automatic idleCycle(input logic rr);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, rr);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h1111, 16'h2222, 1'b0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic             rv0, rv1, rrdy, rr_rst;
    logic [WIDTH-1:0] ra0, rb0, ra1, rb1;
    logic             order [4];

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; rsp_ready = 1'b0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;

    // Reset values
    resetCycle();
    resetCycle();
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);

    // Basic transfer, accepted in the first cycle after reset
    applyStimulus(1'b0, 1'b1, 16'h1234, 16'h00FF, 1'b0, '0, '0, 1'b1);
    checkOutput("basic_accept", 32'(req0_ready), 32'd1);
    idleCycle(1'b1);
    checkOutput("basic_early", 32'(rsp_valid), 32'd0);
    idleCycle(1'b1);
    checkOutput("basic_valid", 32'(rsp_valid), 32'd1);
    checkOutput("basic_data", 32'(rsp_data), 32'h13FE);
    checkOutput("basic_id", 32'(rsp_id), 32'd0);
    idleCycle(1'b1);
    checkOutput("basic_once", 32'(rsp_valid), 32'd0);

    // Wrap-around of the sum
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("wrap_data", 32'(rsp_data), 32'h0000);
    checkOutput("wrap_id", 32'(rsp_id), 32'd1);
    idleCycle(1'b1);

    // Contention after reset: 0,1,0,1
    resetCycle();
    order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0; order[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(16'h0100 + i), 16'h0033, 1'b1, 16'(16'h0200 + i), 16'h0044, 1'b1);
      checkOutput("cont_grant1", 32'(req1_ready), 32'(order[i]));
      checkOutput("cont_grant0", 32'(req0_ready), 32'(!order[i]));
    end
    for (int i = 0; i < 3; i++) idleCycle(1'b1);

    // Backpressure with results pending
    applyStimulus(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0003, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0100, 16'h0100, 1'b0, '0, '0, 1'b1);
    checkOutput("bp_first", 32'(rsp_data), 32'h0002);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h7777, 16'h7777, 1'b1, 16'h6666, 16'h6666, 1'b0);
      checkOutput("bp_ready0", 32'(req0_ready), 32'd0);
      checkOutput("bp_ready1", 32'(req1_ready), 32'd0);
      checkOutput("bp_hold_data", 32'(rsp_data), 32'h0016);
      checkOutput("bp_hold_id", 32'(rsp_id), 32'd0);
    end
    idleCycle(1'b1);
    checkOutput("bp_drain1", 32'(rsp_data), 32'h0016);
    idleCycle(1'b1);
    checkOutput("bp_drain2", 32'(rsp_data), 32'h0200);
    idleCycle(1'b1);
    checkOutput("bp_no_dup", 32'(rsp_valid), 32'd0);

    // Reset with two requests in flight
    applyStimulus(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 16'h3333, 16'h4444, 1'b1);
    resetCycle();
    idleCycle(1'b1);
    checkOutput("flush_none1", 32'(rsp_valid), 32'd0);
    idleCycle(1'b1);
    checkOutput("flush_none2", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0F0F, 16'h00F0, 1'b0, '0, '0, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("flush_next_data", 32'(rsp_data), 32'h10EF);
    checkOutput("flush_next_valid", 32'(rsp_valid), 32'd1);
    idleCycle(1'b1);

    // Constrained random: valids held until accepted, operands wander while
    // waiting, random backpressure and rare resets.
    rv0 = 1'b0; rv1 = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!rv0) rv0 = ($urandom_range(0, 99) < 55);
      if (!rv1) rv1 = ($urandom_range(0, 99) < 55);
      ra0    = 16'($urandom);
      rb0    = 16'($urandom);
      ra1    = 16'($urandom);
      rb1    = 16'($urandom);
      rrdy   = ($urandom_range(0, 99) < 70);
      rr_rst = ($urandom_range(0, 999) == 0);
      applyStimulus(rr_rst, rv0, ra0, rb0, rv1, ra1, rb1, rrdy);
      checkOutput("one_hot", 32'(req0_ready && req1_ready), 32'd0);
      if (req0_ready) rv0 = 1'b0;
      if (req1_ready) rv1 = 1'b0;
    end
    for (int i = 0; i < 4; i++) idleCycle(1'b1);
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
